// File: rtl/wb_regfile.sv
// Write-back register file: 2**ADDR_W GPRs plus HI/LO, with two combinational
// read ports that see the in-flight write-back value (write-first bypass).
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_wreg,
   input  logic [ADDR_W-1:0] wb_wd,
   input  logic [DATA_W-1:0] wb_wdata,
   input  logic              wb_whilo,
   input  logic [DATA_W-1:0] wb_hi,
   input  logic [DATA_W-1:0] wb_lo,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   localparam int N_REG = 2 ** ADDR_W;

   logic [DATA_W-1:0] gpr_q [N_REG];
   logic [DATA_W-1:0] gpr_d [N_REG];
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic [N_REG-1:0]  wr_sel;

   // One-hot write decode; address 0 never selects so $0 stays hard-wired zero.
   always_comb begin
      wr_sel = '0;
      if (wb_wreg && (wb_wd != '0)) begin
         wr_sel[wb_wd] = 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < N_REG; i++) begin
         gpr_d[i] = wr_sel[i] ? wb_wdata : gpr_q[i];
      end
      gpr_d[0] = '0;
   end

   always_comb begin
      hi_d = wb_whilo ? wb_hi : hi_q;
      lo_d = wb_whilo ? wb_lo : lo_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_REG; i++) begin
            gpr_q[i] <= '0;
         end
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         for (int i = 0; i < N_REG; i++) begin
            gpr_q[i] <= gpr_d[i];
         end
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   // Read priority: reset, disabled port, $0, bypass of the current write, stored value.
   function automatic logic [DATA_W-1:0] read_port(
      input logic              rst_n_i,
      input logic              re_i,
      input logic [ADDR_W-1:0] ra_i,
      input logic              wreg_i,
      input logic [ADDR_W-1:0] wd_i,
      input logic [DATA_W-1:0] wdata_i,
      input logic [DATA_W-1:0] stored_i
   );
      logic [DATA_W-1:0] val;
      val = '0;
      if (!rst_n_i) begin
         val = '0;
      end else if (!re_i) begin
         val = '0;
      end else if (ra_i == '0) begin
         val = '0;
      end else if (wreg_i && (ra_i == wd_i)) begin
         val = wdata_i;
      end else begin
         val = stored_i;
      end
      return val;
   endfunction

   always_comb begin
      rdata1 = read_port(rst, re1, raddr1, wb_wreg, wb_wd, wb_wdata, gpr_q[raddr1]);
   end

   always_comb begin
      rdata2 = read_port(rst, re2, raddr2, wb_wreg, wb_wd, wb_wdata, gpr_q[raddr2]);
   end

   always_comb begin
      hi_o = '0;
      lo_o = '0;
      if (rst) begin
         hi_o = hi_d;
         lo_o = lo_d;
      end
   end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_W, default 32, width of GPR, HI and LO data.
REQ-002 Parameter ADDR_W, default 5, GPR address width; register count is 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 wb_wreg  input  1  GPR write enable from the MEM/WB pipeline register.
REQ-006 wb_wd  input  ADDR_W  GPR write address.
REQ-007 wb_wdata  input  DATA_W  GPR write data.
REQ-008 wb_whilo  input  1  HI/LO write enable.
REQ-009 wb_hi  input  DATA_W  HI write data.
REQ-010 wb_lo  input  DATA_W  LO write data.
REQ-011 re1  input  1  read port 1 enable.
REQ-012 raddr1  input  ADDR_W  read port 1 address.
REQ-013 rdata1  output  DATA_W  read port 1 data.
REQ-014 re2  input  1  read port 2 enable.
REQ-015 raddr2  input  ADDR_W  read port 2 address.
REQ-016 rdata2  output  DATA_W  read port 2 data.
REQ-017 hi_o  output  DATA_W  current HI value, bypassed.
REQ-018 lo_o  output  DATA_W  current LO value, bypassed.

Function
REQ-019 The block SHALL hold 2**ADDR_W GPRs of DATA_W bits, plus one HI register and one LO register.
REQ-020 On a rising clk edge with rst high, wb_wreg=1 and wb_wd!=0, the block SHALL write wb_wdata to GPR[wb_wd].
REQ-021 Writes to address 0 SHALL be discarded; GPR[0] SHALL read as 0 at all times.
REQ-022 On a rising clk edge with rst high and wb_whilo=1, the block SHALL load HI<=wb_hi and LO<=wb_lo in the same edge.
REQ-023 HI and LO SHALL hold their values when wb_whilo=0; GPRs SHALL hold their values when not written.
REQ-024 Read ports SHALL be combinational (zero latency) and SHALL be evaluated independently.
REQ-025 Each read port SHALL apply this priority, highest first: rst low -> 0; re=0 -> 0; raddr=0 -> 0; (wb_wreg=1 and raddr=wb_wd) -> wb_wdata (write-first bypass); otherwise GPR[raddr].
REQ-026 Both read ports SHALL be able to hit the same address, including a bypassed one, in the same cycle with identical results.
REQ-027 hi_o/lo_o SHALL equal wb_hi/wb_lo while wb_whilo=1, and the stored HI/LO otherwise; both SHALL be 0 while rst is low.
REQ-028 A GPR write and a HI/LO write in the same cycle SHALL both take effect.
REQ-029 A write presented while rst is low SHALL be ignored.

Reset
REQ-030 Assertion of rst (low) SHALL clear all GPRs, HI and LO to 0 immediately, without waiting for a clk edge.
REQ-031 While rst is low, rdata1, rdata2, hi_o and lo_o SHALL be 0.
REQ-032 Reset asserted mid-sequence SHALL discard the state; the first write after rst deasserts SHALL take effect on the next rising edge.

Verification
REQ-033 Reset: drive rst low mid-cycle after writing GPR[5]=0x1234 -> rdata1 is 0 immediately; after rst goes high, read of 5 returns 0.
REQ-034 Write then read: write GPR[7]=0xDEADBEEF, then next cycle re1=1 raddr1=7 -> rdata1=0xDEADBEEF; with re1=0 -> rdata1=0.
REQ-035 Bypass: wb_wreg=1, wb_wd=9, wb_wdata=0xA5A5A5A5; same cycle re1=re2=1, raddr1=raddr2=9 -> both outputs are 0xA5A5A5A5 before the edge.
REQ-036 Zero register: write $0=0xFFFFFFFF -> both bypass read and next-cycle read of address 0 return 0.
REQ-037 HI/LO: wb_whilo=1, wb_hi=0x1, wb_lo=0x2 -> hi_o/lo_o are 1/2 in that cycle; after wb_whilo drops they hold 1/2; with a concurrent GPR[3]=0x3 write, all three updates are visible.
